// File: rtl/scan_mux_n_pkg.sv
// Shared definitions for the scanning N-channel multiplexer.
package scan_mux_n_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Channel index width; a 1-bit index is kept even for degenerate counts.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_mux_n_if.sv
// Control/data bundle between the lane producer and the scan mux.
interface scan_mux_n_if #(
    parameter int N_CH = 8,
    parameter int W    = 8
);
    import scan_mux_n_pkg::*;

    localparam int SEL_W = sel_width(N_CH);

    logic                en;
    logic                mode;
    logic [SEL_W-1:0]    sel;
    logic [N_CH-1:0]     ch_mask;
    logic [N_CH*W-1:0]   din;
    logic [W-1:0]        dout;
    logic [SEL_W-1:0]    ch_out;
    logic                valid;
    logic                wrap;

    modport master (
        output en, mode, sel, ch_mask, din,
        input  dout, ch_out, valid, wrap
    );

    modport slave (
        input  en, mode, sel, ch_mask, din,
        output dout, ch_out, valid, wrap
    );

endinterface

// File: rtl/scan_mux_n_rr_next_ch.sv
// Finds the next set mask bit strictly above an index, wrapping to the lowest set bit.
module rr_next_ch #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_CH-1:0]  i_mask,
    input  logic [SEL_W-1:0] i_cur_idx,
    output logic [SEL_W-1:0] o_nxt_idx,
    output logic             o_wrapped,
    output logic             o_none
);

    logic [SEL_W-1:0] w_hi;
    logic [SEL_W-1:0] w_lo;
    logic             w_hi_found;

    // Downward scan so the last hit is the lowest qualifying bit.
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_lo = SEL_W'(i);
                if (i > int'(i_cur_idx)) begin
                    w_hi       = SEL_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        o_none    = (i_mask == '0);
        o_nxt_idx = w_hi_found ? w_hi : w_lo;
        o_wrapped = !w_hi_found && !o_none;
    end

endmodule

// File: rtl/scan_mux_n.sv
// Registered N-channel mux with direct select and masked auto-scan with dwell.
module scan_mux_n #(
    parameter int N_CH  = 8,
    parameter int W     = 8,
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    scan_mux_n_if.slave bus
);
    import scan_mux_n_pkg::*;

    localparam int SEL_W = sel_width(N_CH);
    localparam int CNT_W = $clog2(DWELL + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_dout;
    logic [SEL_W-1:0] r_ch_out;
    logic             r_valid;
    logic             r_wrap;
    logic [CNT_W-1:0] r_dwell_cnt;

    logic [SEL_W-1:0] w_ch_nxt;
    logic             w_valid_nxt;
    logic             w_wrap_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;
    logic             w_zero;
    logic [W-1:0]     w_sel_data;
    logic             w_cur_en;

    logic [SEL_W-1:0] w_rr_nxt;
    logic             w_rr_wrapped;
    logic             w_rr_none;

    rr_next_ch #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr (
        .i_mask    (bus.ch_mask),
        .i_cur_idx (r_ch_out),
        .o_nxt_idx (w_rr_nxt),
        .o_wrapped (w_rr_wrapped),
        .o_none    (w_rr_none)
    );

    // Current channel still enabled; loop keeps indexing in range for any N_CH.
    always_comb begin
        w_cur_en = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == r_ch_out && bus.ch_mask[i]) begin
                w_cur_en = 1'b1;
            end
        end
    end

    // Data mux for the channel chosen this cycle; out-of-range index yields zero.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == w_ch_nxt) begin
                w_sel_data = bus.din[i*W +: W];
            end
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch_out;
        w_valid_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_load      = 1'b0;
        w_zero      = 1'b0;
        if (!bus.en) begin
            w_state_nxt = IDLE;
        end else if (bus.mode == MODE_DIRECT) begin
            w_state_nxt = DIRECT;
            w_ch_nxt    = bus.sel;
            if (int'(bus.sel) < N_CH) begin
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
            end else begin
                w_zero = 1'b1;
            end
        end else begin
            w_state_nxt = SCAN;
            if (w_rr_none) begin
                w_zero = 1'b1;
            end else if (r_state != SCAN || !r_valid) begin
                // Entry or resume after an empty mask: stay on ch_out if usable.
                w_ch_nxt    = w_cur_en ? r_ch_out : w_rr_nxt;
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
            end else if (!w_cur_en || r_dwell_cnt == CNT_W'(DWELL - 1)) begin
                w_ch_nxt    = w_rr_nxt;
                w_wrap_nxt  = w_rr_wrapped;
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
            end else begin
                w_cnt_nxt   = r_dwell_cnt + CNT_W'(1);
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and dwell counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= '0;
            r_ch_out    <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_dwell_cnt <= '0;
        end else begin
            if (w_load) begin
                r_dout <= w_sel_data;
            end else if (w_zero) begin
                r_dout <= '0;
            end
            r_ch_out    <= w_ch_nxt;
            r_valid     <= w_valid_nxt;
            r_wrap      <= w_wrap_nxt;
            r_dwell_cnt <= w_cnt_nxt;
        end
    end

    assign bus.dout   = r_dout;
    assign bus.ch_out = r_ch_out;
    assign bus.valid  = r_valid;
    assign bus.wrap   = r_wrap;

endmodule

// File: tb/tb_scan_mux_n.sv
// Directed bench for scan_mux_n: an 8-channel and a 5-channel instance.
module tb_scan_mux_n;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    scan_mux_n_if #(.N_CH(8), .W(8)) bus8 ();
    scan_mux_n_if #(.N_CH(5), .W(8)) bus5 ();

    scan_mux_n #(.N_CH(8), .W(8), .DWELL(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    scan_mux_n #(.N_CH(5), .W(8), .DWELL(4)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave)
    );

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [7:0] mask;
        logic [7:0] dout;
        logic [2:0] ch;
        logic       valid;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] d, input logic [2:0] c,
                        input logic v, input logic w);
        chk({nm, ".dout"},   32'(bus8.dout),   32'(d));
        chk({nm, ".ch_out"}, 32'(bus8.ch_out), 32'(c));
        chk({nm, ".valid"},  32'(bus8.valid),  32'(v));
        chk({nm, ".wrap"},   32'(bus8.wrap),   32'(w));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic m, input logic [2:0] s, input logic [7:0] k,
                       input logic [7:0] d, input logic [2:0] c, input logic v, input logic w);
        vec_t t;
        t.mode = m; t.sel = s; t.mask = k; t.dout = d; t.ch = c; t.valid = v; t.wrap = w;
        vecs.push_back(t);
    endtask

    initial begin
        int ord [4] = '{0, 2, 5, 7};

        // Direct sweep, then park on channel 0 before scanning.
        for (int i = 0; i < 8; i++) add(1'b0, 3'(i), 8'h00, 8'hA0 + 8'(i), 3'(i), 1'b1, 1'b0);
        add(1'b0, 3'd0, 8'h00, 8'hA0, 3'd0, 1'b1, 1'b0);
        // Scan over 0,2,5,7 with four cycles each, wrap on the return to 0.
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                add(1'b1, 3'd0, 8'hA5, 8'hA0 + 8'(ord[k]), 3'(ord[k]), 1'b1, 1'b0);
        add(1'b1, 3'd0, 8'hA5, 8'hA0, 3'd0, 1'b1, 1'b1);

        rst_n        = 1'b0;
        bus8.en      = 1'b0;
        bus8.mode    = 1'b0;
        bus8.sel     = '0;
        bus8.ch_mask = '0;
        bus5.en      = 1'b0;
        bus5.mode    = 1'b0;
        bus5.sel     = '0;
        bus5.ch_mask = '0;
        for (int i = 0; i < 8; i++) bus8.din[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int i = 0; i < 5; i++) bus5.din[i*8 +: 8] = 8'hB0 + 8'(i);

        #12;
        chk8("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("reset5.valid", 32'(bus5.valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk8("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

        bus8.en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus8.mode    = vecs[i].mode;
            bus8.sel     = vecs[i].sel;
            bus8.ch_mask = vecs[i].mask;
            step();
            chk8($sformatf("vec%0d", i), vecs[i].dout, vecs[i].ch, vecs[i].valid, vecs[i].wrap);
        end

        // Walk forward to channel 5 at dwell_cnt=1, then mask it off.
        repeat (3) step();
        chk8("scan_ch0_tail", 8'hA0, 3'd0, 1'b1, 1'b0);
        repeat (4) step();
        chk8("scan_ch2_tail", 8'hA2, 3'd2, 1'b1, 1'b0);
        step();
        step();
        chk8("scan_ch5_cnt1", 8'hA5, 3'd5, 1'b1, 1'b0);
        bus8.ch_mask = 8'h85;
        step();
        chk8("mask_off_cur", 8'hA7, 3'd7, 1'b1, 1'b0);
        bus8.ch_mask = 8'h00;
        step();
        chk8("mask_zero_a", 8'h00, 3'd7, 1'b0, 1'b0);
        step();
        chk8("mask_zero_b", 8'h00, 3'd7, 1'b0, 1'b0);
        bus8.ch_mask = 8'h10;
        step();
        chk8("single_resume", 8'hA4, 3'd4, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk8($sformatf("single_k%0d", k), 8'hA4, 3'd4, 1'b1, (k % 4) == 0);
        end

        // Mode and enable transitions.
        bus8.ch_mask = 8'h04;
        step();
        chk8("scan_to_ch2", 8'hA2, 3'd2, 1'b1, 1'b1);
        bus8.mode = 1'b0;
        bus8.sel  = 3'd6;
        step();
        chk8("scan_to_direct", 8'hA6, 3'd6, 1'b1, 1'b0);
        bus8.en = 1'b0;
        step();
        chk8("disable_a", 8'hA6, 3'd6, 1'b0, 1'b0);
        step();
        chk8("disable_b", 8'hA6, 3'd6, 1'b0, 1'b0);
        bus8.en      = 1'b1;
        bus8.mode    = 1'b1;
        bus8.ch_mask = 8'h01;
        step();
        chk8("reenter_scan", 8'hA0, 3'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-dwell.
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        bus8.en = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        chk8("post_reset_a", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk8("post_reset_b", 8'h00, 3'd0, 1'b0, 1'b0);

        // Five-channel instance: illegal selects.
        bus5.en   = 1'b1;
        bus5.mode = 1'b0;
        bus5.sel  = 3'd6;
        step();
        chk("n5_sel6.dout",  32'(bus5.dout),   32'h00);
        chk("n5_sel6.valid", 32'(bus5.valid),  32'd0);
        chk("n5_sel6.ch",    32'(bus5.ch_out), 32'd6);
        bus5.sel = 3'd4;
        step();
        chk("n5_sel4.dout",  32'(bus5.dout),   32'hB4);
        chk("n5_sel4.valid", 32'(bus5.valid),  32'd1);
        chk("n5_sel4.ch",    32'(bus5.ch_out), 32'd4);
        bus5.sel = 3'd5;
        step();
        chk("n5_sel5.dout",  32'(bus5.dout),   32'h00);
        chk("n5_sel5.valid", 32'(bus5.valid),  32'd0);
        bus5.sel = 3'd0;
        step();
        chk("n5_sel0.dout",  32'(bus5.dout),   32'hB0);
        chk("n5_sel0.valid", 32'(bus5.valid),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
